// File: rtl/systolic_mm_engine_if.sv
// Host-facing bus of the systolic matrix-multiply engine: operand loading,
// job control and the streamed result port.
interface systolic_mm_engine_if #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
);
    localparam int IDX_W = 2 * $clog2(N);

    logic [DATA_W-1:0] data;
    logic              load_in;
    logic              weight_in;
    logic              start;
    logic              in_ready;
    logic              busy;
    logic              start_err;
    logic              done;
    // Result stream: a beat transfers on a rising edge where out_valid and
    // out_ready are both high. While out_valid is high and out_ready is low the
    // engine keeps out_valid, out_data and out_idx unchanged.
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        output data, load_in, weight_in, start, out_ready,
        input  in_ready, busy, start_err, done, out_valid, out_data, out_idx
    );

    modport slave (
        input  data, load_in, weight_in, start, out_ready,
        output in_ready, busy, start_err, done, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic engine computing C = A*B from serially
// loaded operand buffers and streaming C out in row-major order.
module systolic_mm_engine #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter bit SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    systolic_mm_engine_if.slave bus,
    output logic [1:0]          dbg_state
);
    localparam int NN  = N * N;
    localparam int LG  = $clog2(N);
    localparam int PW  = $clog2(NN);
    localparam int CNW = $clog2(NN + 1);
    localparam int CW  = $clog2(3 * N - 2);
    localparam logic [CW-1:0]  LAST_CYC = CW'(3 * N - 3);
    localparam logic [CNW-1:0] FULL     = CNW'(NN);
    localparam logic [PW-1:0]  LAST_PTR = PW'(NN - 1);
    localparam logic [LG-1:0]  LAST_RC  = LG'(N - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DRAIN = 2'd2} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] buf_a [NN];
    logic [DATA_W-1:0] buf_b [NN];
    logic [PW-1:0]     ptr_a, ptr_b;
    logic [CNW-1:0]    cnt_a, cnt_b;
    logic [CW-1:0]     cyc;
    logic [LG-1:0]     di, dj;
    logic [DATA_W-1:0] a_reg [N][N];
    logic [DATA_W-1:0] b_reg [N][N];
    logic [DATA_W-1:0] pe_a  [N][N];
    logic [DATA_W-1:0] pe_b  [N][N];
    logic [ACC_W-1:0]  acc   [N][N];
    logic [DATA_W-1:0] left_feed [N];
    logic [DATA_W-1:0] top_feed  [N];
    logic              start_ok, start_bad, beat, last_beat;
    logic              done_q, start_err_q;

    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
        logic signed [2*DATA_W-1:0] ps;
        logic        [2*DATA_W-1:0] pu;
        ps = (2*DATA_W)'($signed(x)) * (2*DATA_W)'($signed(y));
        pu = (2*DATA_W)'(x) * (2*DATA_W)'(y);
        if (SIGNED) return ACC_W'(ps);
        else        return ACC_W'(pu);
    endfunction

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                if (cnt_a == FULL && cnt_b == FULL) begin
                    start_ok = 1'b1;
                    state_d  = COMPUTE;
                end else begin
                    start_bad = 1'b1;
                end
            end
            COMPUTE: if (cyc == LAST_CYC) state_d = DRAIN;
            DRAIN: begin
                beat      = bus.out_ready;
                last_beat = bus.out_ready && di == LAST_RC && dj == LAST_RC;
                if (last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Skewed edge feeds: row i of A and column i of B start i cycles late.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            left_feed[i] = '0;
            top_feed[i]  = '0;
            if (int'(cyc) >= i && int'(cyc) < i + N) begin
                left_feed[i] = buf_a[PW'(i * N + int'(cyc) - i)];
                top_feed[i]  = buf_b[PW'((int'(cyc) - i) * N + i)];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_left
                assign pe_a[i][j] = left_feed[i];
            end else begin : g_inner_a
                assign pe_a[i][j] = a_reg[i][j-1];
            end
            if (i == 0) begin : g_top
                assign pe_b[i][j] = top_feed[j];
            end else begin : g_inner_b
                assign pe_b[i][j] = b_reg[i-1][j];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_a       <= '0;
            ptr_b       <= '0;
            cnt_a       <= '0;
            cnt_b       <= '0;
            cyc         <= '0;
            di          <= '0;
            dj          <= '0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            for (int k = 0; k < NN; k++) begin
                buf_a[k] <= '0;
                buf_b[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else begin
            done_q      <= last_beat;
            start_err_q <= start_bad;
            if (state_q == IDLE && bus.load_in) begin
                buf_a[ptr_a] <= bus.data;
                ptr_a        <= (ptr_a == LAST_PTR) ? '0 : ptr_a + 1'b1;
                if (cnt_a != FULL) cnt_a <= cnt_a + 1'b1;
            end
            if (state_q == IDLE && bus.weight_in) begin
                buf_b[ptr_b] <= bus.data;
                ptr_b        <= (ptr_b == LAST_PTR) ? '0 : ptr_b + 1'b1;
                if (cnt_b != FULL) cnt_b <= cnt_b + 1'b1;
            end
            if (start_ok) begin
                cyc <= '0;
                di  <= '0;
                dj  <= '0;
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        a_reg[i][j] <= '0;
                        b_reg[i][j] <= '0;
                        acc[i][j]   <= '0;
                    end
                end
            end
            if (state_q == COMPUTE) begin
                cyc <= cyc + 1'b1;
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        a_reg[i][j] <= pe_a[i][j];
                        b_reg[i][j] <= pe_b[i][j];
                        acc[i][j]   <= acc[i][j] + mul_ext(pe_a[i][j], pe_b[i][j]);
                    end
                end
            end
            // cnt_b survives the job so the weights can be reused.
            if (last_beat) begin
                di    <= '0;
                dj    <= '0;
                cnt_a <= '0;
                ptr_a <= '0;
                ptr_b <= '0;
            end else if (beat) begin
                if (dj == LAST_RC) begin
                    dj <= '0;
                    di <= di + 1'b1;
                end else begin
                    dj <= dj + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_data  = (state_q == DRAIN) ? acc[di][dj] : '0;
    assign bus.out_idx   = (state_q == DRAIN) ? {di, dj} : '0;
    assign bus.done      = done_q;
    assign bus.start_err = start_err_q;
    assign dbg_state     = state_q;
endmodule
